// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Generic pipeline stage register with a valid/ready handshake
//            through a two-entry skid buffer. It carries an opaque payload
//            plus PC, branch-delay flag and exception code. A flush empties
//            the stage and loads a redirect PC, so that bubbles still report
//            a meaningful PC.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            in_valid/in_ready     - upstream handshake
//            in_pc/bd/exc/data     - upstream entry fields
//            flush, flush_pc       - discard held entries, redirect out_pc
//            out_valid/out_ready   - downstream handshake
//            out_pc/bd/exc/data    - output entry fields (registered)
//            occupancy             - number of held entries (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int          DATA_W   = 128,
    parameter int          EXC_W    = 5,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic [DATA_W-1:0] in_data,

    input  logic              flush,
    input  logic [31:0]       flush_pc,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic              out_bd,
    output logic [EXC_W-1:0]  out_exc,
    output logic [DATA_W-1:0] out_data,

    output logic [1:0]        occupancy
);

    // ------------------------------------------------------------------------
    // State encoding: the encoding equals the number of held entries, so the
    // occupancy output is the state register itself.
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    // Main entry: drives the out_* ports directly.
    logic [31:0]       r_main_pc;
    logic              r_main_bd;
    logic [EXC_W-1:0]  r_main_exc;
    logic [DATA_W-1:0] r_main_data;

    // Skid entry: catches the one entry accepted while main is stalled.
    logic [31:0]       r_skid_pc;
    logic              r_skid_bd;
    logic [EXC_W-1:0]  r_skid_exc;
    logic [DATA_W-1:0] r_skid_data;

    logic              w_in_fire;
    logic              w_out_fire;

    // Datapath load controls, decoded from state and handshakes.
    logic              w_main_load_in;
    logic              w_main_load_skid;
    logic              w_main_clear;
    logic              w_skid_load;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic. Flush overrides any handshake in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_next = c_ST_ONE;
                    end
                end
                c_ST_ONE: begin
                    if (w_in_fire && !w_out_fire) begin
                        w_state_next = c_ST_FULL;
                    end else if (!w_in_fire && w_out_fire) begin
                        w_state_next = c_ST_EMPTY;
                    end
                end
                c_ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_next = c_ST_ONE;
                    end
                end
                default: begin
                    w_state_next = c_ST_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: output logic. in_ready depends on state only, which keeps the
    // ready path registered between stages.
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state != c_ST_FULL);
        out_valid = (r_state != c_ST_EMPTY);
        occupancy = r_state;
    end

    // ------------------------------------------------------------------------
    // Datapath control decode (flush priority is applied in the registers)
    // ------------------------------------------------------------------------
    always_comb begin
        w_main_load_in   = 1'b0;
        w_main_load_skid = 1'b0;
        w_main_clear     = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            c_ST_EMPTY: begin
                w_main_load_in = w_in_fire;
            end
            c_ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_load_in = 1'b1;
                end else if (w_out_fire) begin
                    w_main_clear = 1'b1;
                end else if (w_in_fire) begin
                    w_skid_load = 1'b1;
                end
            end
            c_ST_FULL: begin
                w_main_load_skid = w_out_fire;
            end
            default: begin
                w_main_clear = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Main entry register. Draining to a bubble clears the payload fields but
    // keeps the PC of the entry just consumed, so exception reporting on a
    // bubble still sees a sensible PC.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_pc   <= PC_RESET;
            r_main_bd   <= 1'b0;
            r_main_exc  <= '0;
            r_main_data <= '0;
        end else if (flush) begin
            r_main_pc   <= flush_pc;
            r_main_bd   <= 1'b0;
            r_main_exc  <= '0;
            r_main_data <= '0;
        end else if (w_main_load_in) begin
            r_main_pc   <= in_pc;
            r_main_bd   <= in_bd;
            r_main_exc  <= in_exc;
            r_main_data <= in_data;
        end else if (w_main_load_skid) begin
            r_main_pc   <= r_skid_pc;
            r_main_bd   <= r_skid_bd;
            r_main_exc  <= r_skid_exc;
            r_main_data <= r_skid_data;
        end else if (w_main_clear) begin
            r_main_bd   <= 1'b0;
            r_main_exc  <= '0;
            r_main_data <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Skid entry register. Its contents are only meaningful in FULL; a flush
    // clears it so no stale entry can ever resurface.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_skid_pc   <= '0;
            r_skid_bd   <= 1'b0;
            r_skid_exc  <= '0;
            r_skid_data <= '0;
        end else if (w_skid_load) begin
            r_skid_pc   <= in_pc;
            r_skid_bd   <= in_bd;
            r_skid_exc  <= in_exc;
            r_skid_data <= in_data;
        end
    end

    assign out_pc   = r_main_pc;
    assign out_bd   = r_main_bd;
    assign out_exc  = r_main_exc;
    assign out_data = r_main_data;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Directed self-checking bench for pipe_stage_skid: reset values,
//            streaming, stall/skid ordering, drain to bubble, flush while
//            full, and reset beating flush.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int DATA_W = 128;
    localparam int EXC_W  = 5;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_pc;
    logic              in_bd;
    logic [EXC_W-1:0]  in_exc;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic [31:0]       flush_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic              out_bd;
    logic [EXC_W-1:0]  out_exc;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    int n_tests;
    int n_fail;

    pipe_stage_skid #(
        .DATA_W   (DATA_W),
        .EXC_W    (EXC_W),
        .PC_RESET (32'h0000_3000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_bd     (in_bd),
        .in_exc    (in_exc),
        .in_data   (in_data),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_bd    (out_bd),
        .out_exc   (out_exc),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle, so outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [EXC_W-1:0] exc,
                         input logic [DATA_W-1:0] data);
        in_valid = v;
        in_pc    = pc;
        in_bd    = 1'b0;
        in_exc   = exc;
        in_data  = data;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        flush_pc  = 32'h0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, '0);

        // ---------------- reset ----------------
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_in_ready",  {127'd0, in_ready},  128'd1);
        check("rst_out_pc",    {96'd0, out_pc},     128'h3000);
        check("rst_occ",       {126'd0, occupancy}, 128'd0);
        check("rst_out_data",  out_data,            128'd0);
        check("rst_out_exc",   {123'd0, out_exc},   128'd0);

        // ---------------- streaming ----------------
        out_ready = 1'b1;
        drive(1'b1, 32'h3000, 5'd0, 128'hD0);
        tick();
        check("str0_pc",    {96'd0, out_pc},     128'h3000);
        check("str0_valid", {127'd0, out_valid}, 128'd1);
        check("str0_occ",   {126'd0, occupancy}, 128'd1);
        drive(1'b1, 32'h3004, 5'd0, 128'hD1);
        tick();
        check("str1_pc",    {96'd0, out_pc},     128'h3004);
        check("str1_valid", {127'd0, out_valid}, 128'd1);
        check("str1_occ",   {126'd0, occupancy}, 128'd1);
        drive(1'b1, 32'h3008, 5'd0, 128'hD2);
        tick();
        check("str2_pc",    {96'd0, out_pc},     128'h3008);
        check("str2_data",  out_data,            128'hD2);
        check("str2_occ",   {126'd0, occupancy}, 128'd1);
        drive(1'b0, 32'h0, 5'd0, '0);
        tick();
        check("str_end_valid", {127'd0, out_valid}, 128'd0);

        // ---------------- stall ----------------
        drive(1'b1, 32'h3000, 5'd0, 128'hA);
        tick();
        check("stl_a_pc", {96'd0, out_pc}, 128'h3000);
        out_ready = 1'b0;
        drive(1'b1, 32'h3004, 5'd0, 128'hB);
        tick();
        check("stl_b_occ",   {126'd0, occupancy}, 128'd2);
        check("stl_b_ready", {127'd0, in_ready},  128'd0);
        check("stl_b_pc",    {96'd0, out_pc},     128'h3000);
        drive(1'b1, 32'h3008, 5'd0, 128'hC);
        tick();
        check("stl_c_occ", {126'd0, occupancy}, 128'd2);
        check("stl_c_pc",  {96'd0, out_pc},     128'h3000);
        out_ready = 1'b1;
        tick();
        check("stl_out_b_pc",   {96'd0, out_pc},     128'h3004);
        check("stl_out_b_data", out_data,            128'hB);
        check("stl_out_b_occ",  {126'd0, occupancy}, 128'd1);
        check("stl_out_b_rdy",  {127'd0, in_ready},  128'd1);
        tick();
        check("stl_out_c_pc",   {96'd0, out_pc}, 128'h3008);
        check("stl_out_c_data", out_data,        128'hC);
        drive(1'b0, 32'h0, 5'd0, '0);
        tick();
        check("stl_end_valid", {127'd0, out_valid}, 128'd0);

        // ---------------- drain to bubble ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'h3010, 5'd4, 128'h5555);
        tick();
        check("drn_exc_held", {123'd0, out_exc}, 128'd4);
        drive(1'b0, 32'h0, 5'd0, '0);
        out_ready = 1'b1;
        tick();
        check("drn_valid", {127'd0, out_valid}, 128'd0);
        check("drn_exc",   {123'd0, out_exc},   128'd0);
        check("drn_data",  out_data,            128'd0);
        check("drn_pc",    {96'd0, out_pc},     128'h3010);

        // ---------------- flush while full ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'h3020, 5'd0, 128'h20);
        tick();
        drive(1'b1, 32'h3024, 5'd0, 128'h24);
        tick();
        check("fl_pre_occ", {126'd0, occupancy}, 128'd2);
        drive(1'b1, 32'h3028, 5'd0, 128'h28);
        flush    = 1'b1;
        flush_pc = 32'h4180;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, '0);
        check("fl_occ",   {126'd0, occupancy}, 128'd0);
        check("fl_pc",    {96'd0, out_pc},     128'h4180);
        check("fl_valid", {127'd0, out_valid}, 128'd0);
        check("fl_ready", {127'd0, in_ready},  128'd1);
        check("fl_data",  out_data,            128'd0);
        tick();
        check("fl_post_occ", {126'd0, occupancy}, 128'd0);

        // ---------------- reset beats flush ----------------
        drive(1'b1, 32'h3030, 5'd0, 128'h30);
        tick();
        drive(1'b1, 32'h3034, 5'd0, 128'h34);
        tick();
        check("rf_pre_occ", {126'd0, occupancy}, 128'd2);
        drive(1'b0, 32'h0, 5'd0, '0);
        reset    = 1'b1;
        flush    = 1'b1;
        flush_pc = 32'h4180;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        check("rf_pc",  {96'd0, out_pc},     128'h3000);
        check("rf_occ", {126'd0, occupancy}, 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register. It is the generalised successor to the fixed-field inter-stage registers. It carries an arbitrary-width payload bundle plus the PC, branch-delay flag and exception code, using a valid/ready handshake through a two-entry skid buffer. Stages can therefore stall independently, for example MEM waiting on a slow bus, without a combinational ready path spanning the whole pipeline. The block also supports flush with a redirect PC so that bubbles carry a correct PC for exception reporting.

## Interface
- DATA_W, 128, width of the opaque payload bundle (instr, operands, results, ...)
- EXC_W, 5, width of the exception-code field
- PC_RESET, 32'h00003000, PC presented on out_pc after reset

- clk  input  1  clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream entry valid
- in_ready  output  1  block can accept an entry this cycle
- in_pc  input  32  entry PC
- in_bd  input  1  entry is in a branch-delay slot
- in_exc  input  EXC_W  entry exception code (0 = none)
- in_data  input  DATA_W  entry payload
- flush  input  1  discard all held entries this cycle
- flush_pc  input  32  PC presented on out_pc after a flush
- out_valid  output  1  output entry valid
- out_ready  input  1  downstream accepts the output entry
- out_pc  output  32  output entry PC
- out_bd  output  1  output entry delay-slot flag
- out_exc  output  EXC_W  output entry exception code
- out_data  output  DATA_W  output entry payload
- occupancy  output  2  number of held entries (0..2)

## Operation
- Storage has two entries, each holding {pc, bd, exc, data}:
  - main: drives all out_* ports directly, with no combinational path from in_*.
  - skid: catches an accepted entry while main is stalled.
- Fire conditions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (occupancy != 2). It depends only on state and never combinationally on out_ready.
- out_valid = (occupancy != 0).
- State EMPTY (occ 0):
  - in_fire → ONE, main ← in.
- State ONE (occ 1):
  - in_fire & out_fire → ONE, main ← in.
  - out_fire only → EMPTY.
  - in_fire only → FULL, skid ← in.
  - Neither → hold.
- State FULL (occ 2):
  - in_ready = 0.
  - out_fire → ONE, main ← skid.
  - Otherwise hold both entries unchanged.
- Entering EMPTY by draining: out_data ← 0, out_exc ← 0, out_bd ← 0. out_pc keeps the PC of the last consumed entry, so a bubble reports the correct PC.
- Priority order: reset > flush > handshake.
- flush:
  - Next state is EMPTY and both entries are invalidated.
  - out_data ← 0, out_exc ← 0, out_bd ← 0, out_pc ← flush_pc.
  - in_fire and out_fire in a flush cycle are ignored. The upstream entry is dropped and the downstream consumer must itself disregard the entry.
- Payload content is never inspected or modified.

## Timing
- Reset values: occupancy 0, out_valid 0, in_ready 1, out_pc PC_RESET, out_bd 0, out_exc 0, out_data 0, skid contents 0.
- Latency: an entry accepted at edge N appears on out_* after edge N when main was free.
- If main was stalled, the entry appears one edge after main is consumed.
- Throughput: one entry per cycle sustained when out_ready is held high.
- Buffering: at most one extra entry is accepted after out_ready drops. in_ready falls on the edge that fills skid.
- in_ready rises on the edge after the out_fire that empties skid (FULL → ONE).
- Entry order is strictly FIFO; no entry is lost or duplicated except by flush.
- Reset or flush asserted mid-stall (FULL): takes effect at the next edge, and the block accepts again in the following cycle.
- flush with flush_pc equal to the current out_pc is legal and yields the same state as any other flush.

## Test plan
- Reset with DATA_W=128: after reset, out_valid=0, in_ready=1, out_pc=0x00003000, occupancy=0, out_data=0.
- Streaming: out_ready=1, feed pc 0x3000/0x3004/0x3008 on consecutive cycles → the same sequence appears on out_pc one cycle later, out_valid continuously 1, occupancy 1.
- Stall:
  - Setup: feed A (pc 0x3000), then drop out_ready, then feed B (0x3004) and C (0x3008).
  - Required: B goes to skid, occupancy=2, in_ready=0, and C is held upstream.
  - Then raise out_ready: output order is A, B, C, with no loss.
- Drain to bubble: one entry pc 0x3010 exc 4 consumed with no new input → out_valid=0, out_exc=0, out_data=0, out_pc stays 0x3010.
- Flush in FULL with in_valid=1: flush_pc=0x4180 → next cycle occupancy=0, out_pc=0x4180, out_valid=0, in_ready=1; the upstream entry is not captured.
- Reset and flush asserted together while FULL → out_pc=0x00003000 (reset wins), occupancy=0.
